// File: rtl/shift_seq_pkg.sv
// Shared mode and state encodings for the sequential shift engine.
package shift_seq_pkg;

    localparam logic [2:0] MODE_SLL  = 3'b000;
    localparam logic [2:0] MODE_SRL  = 3'b001;
    localparam logic [2:0] MODE_SRA  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_SLI  = 3'b101;
    localparam logic [2:0] MODE_SRI  = 3'b110;
    localparam logic [2:0] MODE_HOLD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step: next register value and the bit pushed out.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] nxt,
    output logic             ej
);

    always_comb begin
        nxt = value;
        ej  = 1'b0;
        case (mode)
            MODE_SLL: begin
                nxt = {value[WIDTH-2:0], 1'b0};
                ej  = value[WIDTH-1];
            end
            MODE_SRL: begin
                nxt = {1'b0, value[WIDTH-1:1]};
                ej  = value[0];
            end
            MODE_SRA: begin
                nxt = {value[WIDTH-1], value[WIDTH-1:1]};
                ej  = value[0];
            end
            MODE_ROL: begin
                nxt = {value[WIDTH-2:0], value[WIDTH-1]};
                ej  = value[WIDTH-1];
            end
            MODE_ROR: begin
                nxt = {value[0], value[WIDTH-1:1]};
                ej  = value[0];
            end
            MODE_SLI: begin
                nxt = {value[WIDTH-2:0], ser_in};
                ej  = value[WIDTH-1];
            end
            MODE_SRI: begin
                nxt = {ser_in, value[WIDTH-1:1]};
                ej  = value[0];
            end
            MODE_HOLD: begin
                nxt = value;
                ej  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_engine.sv
// Multi-cycle shifter: start/busy/done FSM stepping shift_step once per cycle.
module shift_seq_engine
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] din,
    input  logic [CNT_W-1:0] count,
    input  logic             ser_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             ser_out
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_q;
    logic [WIDTH-1:0] step_val;
    logic             step_bit;

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value (dout),
        .mode  (mode_q),
        .ser_in(ser_in),
        .nxt   (step_val),
        .ej    (step_bit)
    );

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (count == '0) ? DONE : RUN;
                else
                    state_nxt = IDLE;
            end
            RUN: begin
                // cnt==0 here cannot occur, but exits rather than stalls
                if (cnt <= CNT_W'(1))
                    state_nxt = DONE;
                else
                    state_nxt = RUN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= MODE_SLL;
            dout    <= '0;
            ser_out <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        dout    <= din;
                        mode_q  <= mode;
                        cnt     <= count;
                        ser_out <= 1'b0;
                    end
                end
                RUN: begin
                    dout    <= step_val;
                    ser_out <= step_bit;
                    if (cnt != '0)
                        cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);
    assign zero = (dout == '0);

endmodule

// File: doc/shift_seq_engine.md
Name: shift_seq_engine

Overview:
- Parametrised sequential shift engine; next generation of the team's load/shift-left register plus zero-detect counter.
- Loads an operand and applies one of seven shift/rotate modes, one bit per cycle, for a programmable count.
- Uses a start/busy/done handshake and reports zero and serial-out flags.
- Sits beside the ALU as the multi-cycle shifter for shift-class instructions.

Parameters:
- WIDTH, 8, data width in bits (>=2).
- CNT_W, 4, shift-count width; maximum count is 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock; the only clock in the block.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  3  operation, latched on an accepted start.
- din  input  WIDTH  operand, latched on an accepted start.
- count  input  CNT_W  number of 1-bit steps, latched on an accepted start.
- ser_in  input  1  fill bit for modes 101/110; sampled every RUN cycle.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle completion pulse.
- dout  output  WIDTH  shift register contents.
- zero  output  1  combinational, (dout == 0).
- ser_out  output  1  bit ejected by the most recent step.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, dout=0, internal counter=0, ser_out=0, busy=0, done=0; zero therefore reads 1.
  - The operation in progress is abandoned.
- Modes:
  - 000 SLL, zero fill.
  - 001 SRL, zero fill.
  - 010 SRA, MSB replicated.
  - 011 ROL.
  - 100 ROR.
  - 101 SLL, ser_in fill.
  - 110 SRL, ser_in fill.
  - 111 HOLD: dout unchanged and ser_out=0, but the count still runs.
- ser_out per step:
  - Left modes: the pre-shift MSB.
  - Right modes: the pre-shift LSB.
  - Rotates: the wrapped bit.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge (edge 0):
  - dout<=din; mode and count are latched; ser_out<=0.
  - count!=0 -> RUN with the counter at count.
  - count==0 -> DONE directly.
- RUN, each edge:
  - Apply one step; counter decrements.
  - When the counter goes 1->0, next state is DONE.
  - Exactly `count` steps are applied; the last step occurs at edge `count`.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge. dout holds the result until the next accepted start.
- Latency: done is high in the cycle after edge max(count,0) counted from the start edge. Throughput is one operation per count+2 cycles.
- start while busy (RUN or DONE) is ignored: no queuing and no error. A new start is accepted only in the cycle after done.
- Width rules:
  - Counter is CNT_W bits and never underflows.
  - count > WIDTH is legal. Logical shifts saturate to all-zero (or all-ser_in); rotates wrap modulo WIDTH.
- mode, din and count changing during RUN have no effect.

Decomposition:
- Package shift_seq_pkg:
  - Mode localparams MODE_SLL..MODE_HOLD.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - State 2'd3 is illegal and recovers to IDLE.
- Sub-module shift_step: combinational, parametrised by WIDTH; inputs value, mode, ser_in; outputs next value and ejected bit.
- shift_seq_engine holds only the FSM, counter and registers.

Test Plan (WIDTH=8, CNT_W=4):
- Reset: rst_n=0 asynchronously, mid-cycle -> dout=8'h00, busy=0, done=0, zero=1, ser_out=0 immediately, with no clock edge.
- SLL: din=8'h81, count=3, mode=000 -> busy for 4 cycles; done in the cycle after edge 3; dout=8'h08; ser_out=0.
- SRA: din=8'hA0, count=2, mode=010 -> dout=8'hE8, ser_out=0, zero=0. Then ROR din=8'h01 count=1 -> dout=8'h80, ser_out=1.
- ROL din=8'h96 count=8, with start re-pulsed at cycle 3 -> the second start is ignored; dout=8'h96 on done; done pulses exactly once.
- count=0, din=8'h00, mode=001 -> done in the very next cycle; dout=8'h00; zero=1; no RUN cycle. Then mode=101, din=8'h00, ser_in=1, count=3 -> dout=8'h07.
- Reset mid-RUN: SLL din=8'hFF count=5, rst_n=0 after 2 steps -> dout=0 and busy=0 at once. After release, start SRL din=8'h10 count=4 -> dout=8'h01, ser_out=0, done pulses once.
